// File: rtl/ir_loader_if.sv
// Byte-stream handshake plus byte-wide instruction-memory write port used by ir_loader.
// The master drives the stream and observes the writes; the slave is the loader.
interface ir_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ir_loader.sv
// Loads a little-endian byte stream into instruction memory, one byte write per accepted byte.
// Optional IR_LOADER_CHECKSUM_EN: a trailing XOR checksum word is checked when the load ends.
module ir_loader #(
  parameter int unsigned MEM_BYTES = 128,
  parameter int unsigned CNT_W     = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [31:0]      base_addr_i,
  input  logic [CNT_W-1:0] num_words_i,
  ir_loader_if.slave       bus,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] word_cnt_o,
  output logic             err_o
);

  localparam int unsigned IdxW = CNT_W + 3;

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e           state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [CNT_W-1:0] nwords_q, nwords_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rdy_q, rdy_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;

  logic [IdxW-1:0]  data_bytes;
  logic [IdxW-1:0]  last_idx;
  logic [32:0]      end_addr;
  logic             accept;
  logic             data_phase;

  assign data_bytes = {1'b0, nwords_q, 2'b00};
  // One extra bit so a base near 2^32 cannot wrap past the range check.
  assign end_addr   = {1'b0, base_addr_i} + 33'({num_words_i, 2'b00});
  assign accept     = (state_q == StLoad) && rdy_q && bus.in_valid;

`ifdef IR_LOADER_CHECKSUM_EN
  logic [31:0] word_q, word_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] word_next;

  assign last_idx   = data_bytes + IdxW'(3);
  assign data_phase = idx_q < data_bytes;
  assign word_next  = {bus.in_data, word_q[31:8]};
`else
  assign last_idx   = data_bytes - IdxW'(1);
  assign data_phase = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    nwords_d   = nwords_q;
    word_cnt_d = word_cnt_q;
    idx_d      = idx_q;
    err_d      = err_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rdy_d      = rdy_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef IR_LOADER_CHECKSUM_EN
    word_d     = word_q;
    acc_d      = acc_q;
`endif
    case (state_q)
      StIdle: begin
        if (start_i) begin
          word_cnt_d = '0;
          idx_d      = '0;
          if (num_words_i == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
            err_d   = 1'b0;
          end else if (base_addr_i[1:0] != 2'b00 || end_addr > 33'(MEM_BYTES)) begin
            state_d = StDone;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d  = StLoad;
            base_d   = base_addr_i;
            nwords_d = num_words_i;
            err_d    = 1'b0;
            busy_d   = 1'b1;
            rdy_d    = 1'b1;
`ifdef IR_LOADER_CHECKSUM_EN
            acc_d    = '0;
`endif
          end
        end
      end
      StLoad: begin
        if (accept) begin
          idx_d = idx_q + IdxW'(1);
          if (data_phase) begin
            we_d    = 1'b1;
            addr_d  = base_q + 32'(idx_q);
            wdata_d = bus.in_data;
            if (idx_q[1:0] == 2'b11) word_cnt_d = word_cnt_q + CNT_W'(1);
          end
`ifdef IR_LOADER_CHECKSUM_EN
          word_d = word_next;
          if (data_phase && idx_q[1:0] == 2'b11) acc_d = acc_q ^ word_next;
`endif
          if (idx_q == last_idx) begin
            state_d = StDone;
            rdy_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`ifdef IR_LOADER_CHECKSUM_EN
            err_d   = (word_next != acc_q);
`endif
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      base_q     <= '0;
      nwords_q   <= '0;
      word_cnt_q <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rdy_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef IR_LOADER_CHECKSUM_EN
      word_q     <= '0;
      acc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      nwords_q   <= nwords_d;
      word_cnt_q <= word_cnt_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rdy_q      <= rdy_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
`ifdef IR_LOADER_CHECKSUM_EN
      word_q     <= word_d;
      acc_q      <= acc_d;
`endif
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign word_cnt_o    = word_cnt_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_ir_loader.sv
// Randomized bench for ir_loader: a byte-list memory model predicts every write, flag and word.
module tb_ir_loader;
  localparam int unsigned MEM_BYTES = 128;
  localparam int unsigned CNT_W     = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic [31:0]      base_addr_i = '0;
  logic [CNT_W-1:0] num_words_i = '0;
  logic             busy_o, done_o, err_o;
  logic [CNT_W-1:0] word_cnt_o;

  ir_loader_if bus ();

  ir_loader #(
    .MEM_BYTES (MEM_BYTES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .num_words_i (num_words_i),
    .bus         (bus),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .word_cnt_o  (word_cnt_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  // Instruction memory driven by the DUT write port, and the bench's expected image.
  logic [7:0] dmem    [0:MEM_BYTES-1];
  logic [7:0] ref_mem [0:MEM_BYTES-1];
  logic [7:0] stim    [0:255];
  logic       mem_clr = 1'b1;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < int'(MEM_BYTES); i++) dmem[i] <= 8'h00;
    end else if (bus.mem_we && bus.mem_addr < MEM_BYTES) begin
      dmem[bus.mem_addr[6:0]] <= bus.mem_wdata;
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dut_word(input int a);
    return {dmem[a+3], dmem[a+2], dmem[a+1], dmem[a]};
  endfunction

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  // Runs one start request. vmode: 0 valid held, 1 toggling, 2 random. poke: LOAD cycle
  // at which a stray start is pulsed (-1 none). flip: XOR applied to the correct checksum.
  task automatic do_load(input logic [31:0] base, input int nw, input int vmode,
                         input int poke, input logic [31:0] flip);
    bit          ok, pend, seen, v, exp_err;
    int          dbytes, total, idx, cyc, budget;
    logic [31:0] x, paddr;
    logic [7:0]  pdata;

    ok = (nw > 0) && (base[1:0] == 2'b00) &&
         (({32'd0, base} + 64'(4 * nw)) <= 64'(MEM_BYTES));
    dbytes = ok ? 4 * nw : 0;
    x = '0;
    for (int w = 0; w < nw; w++)
      x ^= {stim[4*w+3], stim[4*w+2], stim[4*w+1], stim[4*w]};
`ifdef IR_LOADER_CHECKSUM_EN
    x ^= flip;
    {stim[dbytes+3], stim[dbytes+2], stim[dbytes+1], stim[dbytes]} = x;
    total   = ok ? dbytes + 4 : 0;
    exp_err = ok ? (flip != 0) : (nw > 0);
`else
    total   = dbytes;
    exp_err = !ok && (nw > 0);
`endif

    @(posedge clk); #1;
    start_i      = 1'b1;
    base_addr_i  = base;
    num_words_i  = CNT_W'(nw);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("idle_busy", busy_o, 0);
    check("idle_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    start_i = 1'b0;

    idx = 0; pend = 0; seen = 0; cyc = 0; paddr = '0; pdata = '0;
    budget = 8 * total + 16;
    while (!seen && cyc < budget) begin
      if (cyc == poke) begin
        start_i     = 1'b1;
        base_addr_i = $urandom;
        num_words_i = CNT_W'($urandom);
      end else begin
        start_i = 1'b0;
      end
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (idx >= total) v = 1'b1;  // an extra byte held valid after the last one
      bus.in_valid = v;
      bus.in_data  = (idx < total) ? stim[idx] : 8'($urandom);
      @(negedge clk);
      check("mem_we", bus.mem_we, pend);
      if (pend) begin
        check("mem_addr", bus.mem_addr, paddr);
        check("mem_wdata", bus.mem_wdata, pdata);
      end
      if (done_o) begin
        seen = 1;
        check("done_at_idx", idx, total);
        check("done_busy", busy_o, 0);
        check("done_ready", bus.in_ready, 0);
      end else begin
        check("load_busy", busy_o, 1);
        check("load_ready", bus.in_ready, idx < total);
      end
      pend = v && bus.in_ready && (idx < dbytes);
      if (idx < total) begin
        paddr = base + 32'(idx);
        pdata = stim[idx];
      end
      if (v && bus.in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    start_i = 1'b0;
    if (!seen) check("done_timeout", 0, 1);

    @(negedge clk);
    check("post_we", bus.mem_we, 0);
    check("post_done", done_o, 0);
    check("post_ready", bus.in_ready, 0);
    check("word_cnt", word_cnt_o, ok ? nw : 0);
    check("err", err_o, exp_err);
    bus.in_valid = 1'b0;

    if (ok) begin
      for (int i = 0; i < dbytes; i++) ref_mem[base + 32'(i)] = stim[i];
      for (int w = 0; w < nw; w++)
        check("mem_word", dut_word(int'(base) + 4 * w), ref_word(int'(base) + 4 * w));
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = 8'h00;
    #12;
    check("rst_state", {bus.in_ready, busy_o, done_o, bus.mem_we, err_o, word_cnt_o,
                        bus.mem_addr, bus.mem_wdata}, 0);
    @(negedge clk);
    mem_clr = 1'b0;
    rst_n   = 1'b1;

    // Basic little-endian word at address 4.
    {stim[0], stim[1], stim[2], stim[3]} = {8'h26, 8'h00, 8'h02, 8'h34};
    do_load(32'h4, 1, 0, -1, 32'h0);
    check("word_at_4", dut_word(4), 32'h3402_0026);

    // Toggling valid, two words.
    for (int i = 0; i < 8; i++) stim[i] = 8'($urandom);
    do_load(32'h20, 2, 1, -1, 32'h0);

    // Out of range and misaligned requests.
    do_load(32'h7C, 2, 0, -1, 32'h0);
    do_load(32'h2, 1, 0, -1, 32'h0);

    // Stray start during LOAD, then an empty load.
    for (int i = 0; i < 4; i++) stim[i] = 8'($urandom);
    do_load(32'h40, 1, 0, 2, 32'h0);
    do_load(32'h0, 0, 0, -1, 32'h0);

    // Checksum pair: correct, then a zero checksum over the same data.
    {stim[0], stim[1], stim[2], stim[3]} = {8'h26, 8'h00, 8'h02, 8'h34};
    {stim[4], stim[5], stim[6], stim[7]} = {8'h34, 8'h00, 8'h03, 8'h34};
    do_load(32'h50, 2, 0, -1, 32'h0);
    do_load(32'h50, 2, 0, -1, 32'h0001_0012);
    check("word_at_50", dut_word(32'h50), 32'h3402_0026);

    // Reset after two bytes of a load.
    stim[0] = 8'hA5;
    stim[1] = 8'h5A;
    @(posedge clk); #1;
    start_i     = 1'b1;
    base_addr_i = 32'h10;
    num_words_i = CNT_W'(2);
    @(posedge clk); #1;
    start_i      = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = stim[0];
    @(posedge clk); #1;
    bus.in_data  = stim[1];
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_busy", busy_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out", {bus.in_ready, busy_o, done_o, bus.mem_we, err_o, word_cnt_o,
                          bus.mem_addr, bus.mem_wdata}, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 1) rst_n = 1'b1;
      check("rst_no_done", done_o, 0);
    end
    ref_mem[8'h10] = stim[0];
    ref_mem[8'h11] = stim[1];
    check("rst_kept_b0", dmem[8'h10], stim[0]);
    check("rst_kept_b1", dmem[8'h11], stim[1]);

    // Randomized loads.
    for (int t = 0; t < 14; t++) begin
      int          nw;
      logic [31:0] base, flip;
      nw   = int'($urandom_range(0, 6));
      base = ($urandom_range(0, 9) == 0) ? $urandom : 32'(4 * $urandom_range(0, 31));
      for (int i = 0; i < 4 * nw; i++) stim[i] = 8'($urandom);
      flip = ($urandom_range(0, 1) == 0) ? 32'h0 : ($urandom | 32'h1);
      do_load(base, nw, int'($urandom_range(0, 2)), -1, flip);
    end

    for (int w = 0; w < int'(MEM_BYTES) / 4; w++)
      check("final_mem", dut_word(4 * w), ref_word(4 * w));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
